// File: rtl/ddr_pkg.sv
// Shared definitions for the rhythm-game judging path: verdict encoding,
// point values, arrow bit positions and the press-grading rule.
package ddr_pkg;

    typedef enum logic [1:0] {
        J_NONE,
        J_GOOD,
        J_PERFECT,
        J_MISS
    } judge_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_ARMED,
        P_DONE
    } player_state_e;

    localparam int PTS_PERFECT = 2;
    localparam int PTS_GOOD    = 1;

    localparam int UP    = 3;
    localparam int DOWN  = 2;
    localparam int LEFT  = 1;
    localparam int RIGHT = 0;

    function automatic logic arrowOneHot(input logic [3:0] arrows);
        int count;
        count = int'(arrows[UP]) + int'(arrows[DOWN]) + int'(arrows[LEFT]) + int'(arrows[RIGHT]);
        return (count == 1);
    endfunction

    // Any stray arrow makes the press a miss, even alongside the correct one.
    function automatic judge_e judgePress(input logic [3:0] press,
                                          input logic [3:0] dir,
                                          input logic       early);
        if (press == 4'b0000)
            return J_NONE;
        else if ((press & ~dir) != 4'b0000)
            return J_MISS;
        else if (press == dir)
            return early ? J_PERFECT : J_GOOD;
        else
            return J_NONE;
    endfunction

endpackage

// File: rtl/hit_judge_player.sv
// One player's judge: rising-edge detect on the arrow levels, a per-note
// verdict FSM, and saturating score/combo counters.
module hit_judge_player
    import ddr_pkg::*;
#(
    parameter int SCORE_W = 16,
    parameter int COMBO_W = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [3:0]         btn_i,
    input  logic               open_i,
    input  logic               last_i,
    input  logic               early_i,
    input  logic [3:0]         dir_i,
    output logic               hit_o,
    output logic               perfect_o,
    output logic               miss_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [COMBO_W-1:0] combo_o
);

    player_state_e      state_q;
    logic [3:0]         btn_q;
    logic               hit_q;
    logic               perfect_q;
    logic               miss_q;
    logic [SCORE_W-1:0] score_q;
    logic [COMBO_W-1:0] combo_q;

    logic [3:0]         press;
    judge_e             verdict;
    logic [SCORE_W:0]   sumPerfect;
    logic [SCORE_W:0]   sumGood;
    logic [SCORE_W-1:0] scorePerfect_d;
    logic [SCORE_W-1:0] scoreGood_d;
    logic [COMBO_W-1:0] comboHit_d;

    assign press   = btn_i & ~btn_q;
    assign verdict = judgePress(press, dir_i, early_i);

    // The extra carry bit flags overflow so the score pins at all-ones.
    assign sumPerfect     = {1'b0, score_q} + (SCORE_W+1)'(PTS_PERFECT);
    assign sumGood        = {1'b0, score_q} + (SCORE_W+1)'(PTS_GOOD);
    assign scorePerfect_d = sumPerfect[SCORE_W] ? '1 : sumPerfect[SCORE_W-1:0];
    assign scoreGood_d    = sumGood[SCORE_W] ? '1 : sumGood[SCORE_W-1:0];
    assign comboHit_d     = (&combo_q) ? combo_q : combo_q + COMBO_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= P_IDLE;
            btn_q     <= 4'b0000;
            hit_q     <= 1'b0;
            perfect_q <= 1'b0;
            miss_q    <= 1'b0;
            score_q   <= '0;
            combo_q   <= '0;
        end else begin
            btn_q     <= btn_i;
            hit_q     <= 1'b0;
            perfect_q <= 1'b0;
            miss_q    <= 1'b0;
            case (state_q)
                P_IDLE: begin
                    if (open_i)
                        state_q <= P_ARMED;
                end
                P_ARMED: begin
                    // A press on the final window cycle wins over the timeout.
                    if (verdict != J_NONE) begin
                        state_q <= last_i ? P_IDLE : P_DONE;
                        if (verdict == J_MISS) begin
                            miss_q  <= 1'b1;
                            combo_q <= '0;
                        end else begin
                            hit_q     <= 1'b1;
                            perfect_q <= (verdict == J_PERFECT);
                            score_q   <= (verdict == J_PERFECT) ? scorePerfect_d : scoreGood_d;
                            combo_q   <= comboHit_d;
                        end
                    end else if (last_i) begin
                        state_q <= P_IDLE;
                        miss_q  <= 1'b1;
                        combo_q <= '0;
                    end
                end
                P_DONE: begin
                    if (last_i)
                        state_q <= P_IDLE;
                end
                default: state_q <= P_IDLE;
            endcase
        end
    end

    assign hit_o     = hit_q;
    assign perfect_o = perfect_q;
    assign miss_o    = miss_q;
    assign score_o   = score_q;
    assign combo_o   = combo_q;

endmodule

// File: rtl/hit_judge.sv
// Two-player hit judge: a shared hit window (counter, busy, latched target
// arrow) feeding one independent judge per player.
module hit_judge
    import ddr_pkg::*;
#(
    parameter int WINDOW      = 25_000_000,
    parameter int PERFECT_WIN = 5_000_000,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         a_btn,
    input  logic [3:0]         b_btn,
    input  logic               note_start,
    input  logic [3:0]         note_dir,
    output logic               busy,
    output logic               a_hit,
    output logic               b_hit,
    output logic               a_perfect,
    output logic               b_perfect,
    output logic               a_miss,
    output logic               b_miss,
    output logic [SCORE_W-1:0] a_score,
    output logic [SCORE_W-1:0] b_score,
    output logic [COMBO_W-1:0] a_combo,
    output logic [COMBO_W-1:0] b_combo
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] winCnt_q, winCnt_d;
    logic [3:0]       dir_q, dir_d;

    logic             windowOpen;
    logic             windowLast;
    logic             windowEarly;

    // Starts arriving while busy or with a malformed direction are dropped.
    assign windowOpen  = note_start && !busy_q && arrowOneHot(note_dir);
    assign windowLast  = busy_q && (winCnt_q == CNT_W'(WINDOW - 1));
    assign windowEarly = int'(winCnt_q) < PERFECT_WIN;

    always_comb begin
        busy_d   = busy_q;
        winCnt_d = winCnt_q;
        dir_d    = dir_q;
        if (windowOpen) begin
            busy_d   = 1'b1;
            winCnt_d = '0;
            dir_d    = note_dir;
        end else if (busy_q) begin
            if (windowLast) begin
                busy_d   = 1'b0;
                winCnt_d = '0;
            end else begin
                winCnt_d = winCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q   <= 1'b0;
            winCnt_q <= '0;
            dir_q    <= 4'b0000;
        end else begin
            busy_q   <= busy_d;
            winCnt_q <= winCnt_d;
            dir_q    <= dir_d;
        end
    end

    assign busy = busy_q;

    hit_judge_player #(
        .SCORE_W (SCORE_W),
        .COMBO_W (COMBO_W)
    ) u_playerA (
        .clk_i     (clock),
        .reset_i   (reset),
        .btn_i     (a_btn),
        .open_i    (windowOpen),
        .last_i    (windowLast),
        .early_i   (windowEarly),
        .dir_i     (dir_q),
        .hit_o     (a_hit),
        .perfect_o (a_perfect),
        .miss_o    (a_miss),
        .score_o   (a_score),
        .combo_o   (a_combo)
    );

    hit_judge_player #(
        .SCORE_W (SCORE_W),
        .COMBO_W (COMBO_W)
    ) u_playerB (
        .clk_i     (clock),
        .reset_i   (reset),
        .btn_i     (b_btn),
        .open_i    (windowOpen),
        .last_i    (windowLast),
        .early_i   (windowEarly),
        .dir_i     (dir_q),
        .hit_o     (b_hit),
        .perfect_o (b_perfect),
        .miss_o    (b_miss),
        .score_o   (b_score),
        .combo_o   (b_combo)
    );

endmodule
